// File: rtl/demux4_buffered.sv
// 1-to-4 demultiplexer with a one-entry holding register, valid/ready handshake
// and wrapping delivered-word counter on each output channel.
module demux4_buffered #(
    parameter int OPERAND_WIDTH = 32,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_select,
    input  logic [OPERAND_WIDTH-1:0]   in_data,
    output logic [3:0]                 out_valid,
    input  logic [3:0]                 out_ready,
    output logic [4*OPERAND_WIDTH-1:0] out_data,
    output logic [4*COUNT_WIDTH-1:0]   out_count
);

    logic [OPERAND_WIDTH-1:0] data_q [4];
    logic [COUNT_WIDTH-1:0]   cnt_q  [4];
    logic [3:0]               valid_q;
    logic [3:0]               fill;
    logic [3:0]               drain;

    // Only the selected channel gates the input, so a full target blocks all traffic.
    assign in_ready = !valid_q[in_select] || out_ready[in_select];

    always_comb begin
        fill  = 4'b0000;
        drain = valid_q & out_ready;
        if (in_valid && in_ready) begin
            fill[in_select] = 1'b1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end else begin
                if (fill[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= in_data;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (drain[k]) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end

        assign out_data[k*OPERAND_WIDTH +: OPERAND_WIDTH] = data_q[k];
        assign out_count[k*COUNT_WIDTH +: COUNT_WIDTH]    = cnt_q[k];
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux4_buffered.sv
// Directed and scoreboarded random bench for demux4_buffered.
module tb_demux4_buffered;

    localparam int W  = 32;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_select;
    logic [W-1:0]   in_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
    logic [4*CW-1:0] out_count;

    int passed = 0;
    int total  = 0;

    demux4_buffered #(.OPERAND_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dat(int k);
        return out_data[k*W +: W];
    endfunction

    function automatic logic [CW-1:0] cnt(int k);
        return out_count[k*CW +: CW];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; in_select = 2'd0; in_data = '0; out_ready = 4'b0000;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_select = 2'd0; in_data = '0; out_ready = 4'b0000;
        tick;
        total++; if (out_valid !== 4'b0000) $display("FAIL reset_valid: got %b expected 0000", out_valid); else passed++;
        total++; if (out_count !== '0) $display("FAIL reset_count: got %h expected 0", out_count); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_data: got %h expected 0", out_data); else passed++;
        rst = 1'b0;
        tick;
        in_valid = 1'b1; in_select = 2'd2; in_data = 32'h77;
        tick;
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 4'b0100) $display("FAIL pre_reset_fill: got %b expected 0100", out_valid); else passed++;
        total++; if (dat(2) !== 32'h77) $display("FAIL pre_reset_data: got %h expected 77", dat(2)); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 4'b0000) $display("FAIL async_reset_valid: got %b expected 0000", out_valid); else passed++;
        total++; if (out_count !== '0) $display("FAIL async_reset_count: got %h expected 0", out_count); else passed++;
        total++; if (out_data !== '0) $display("FAIL async_reset_data: got %h expected 0", out_data); else passed++;
        tick;
        rst = 1'b0;
        in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_select = 2'(s);
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready sel=%0d: got %b expected 1", s, in_ready); else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_routing;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_select = 2'(k); in_data = 32'hA0 + k;
            tick;
        end
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 4'b1111) $display("FAIL route_valid: got %b expected 1111", out_valid); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (dat(k) !== 32'hA0 + k) $display("FAIL route_data ch%0d: got %h expected %h", k, dat(k), 32'hA0 + k); else passed++;
        end
        in_valid = 1'b1; in_select = 2'd1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL route_full_ready: got %b expected 0", in_ready); else passed++;
        in_valid = 1'b0; out_ready = 4'b1111;
        tick;
        total++; if (out_valid !== 4'b0000) $display("FAIL route_drain_valid: got %b expected 0000", out_valid); else passed++;
        total++; if (out_count !== {4{8'd1}}) $display("FAIL route_drain_count: got %h expected 01010101", out_count); else passed++;
        total++; if (dat(3) !== 32'hA3) $display("FAIL route_hold_after_drain: got %h expected a3", dat(3)); else passed++;
        out_ready = 4'b0000;
    endtask

    task automatic test_streaming;
        do_reset;
        out_ready = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_select = 2'd3; in_data = 32'h100 + i;
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL stream_ready i=%0d: got %b expected 1", i, in_ready); else passed++;
            tick;
            total++; if (out_valid !== 4'b1000) $display("FAIL stream_valid i=%0d: got %b expected 1000", i, out_valid); else passed++;
            total++; if (dat(3) !== 32'h100 + i) $display("FAIL stream_data i=%0d: got %h expected %h", i, dat(3), 32'h100 + i); else passed++;
        end
        in_valid = 1'b0;
        tick;
        total++; if (cnt(3) !== 8'd10) $display("FAIL stream_count: got %0d expected 10", cnt(3)); else passed++;
        total++; if (out_valid !== 4'b0000) $display("FAIL stream_empty: got %b expected 0000", out_valid); else passed++;
        out_ready = 4'b0000;
    endtask

    task automatic test_head_of_line;
        do_reset;
        in_valid = 1'b1; in_select = 2'd0; in_data = 32'h11;
        tick;
        in_data = 32'h55;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL hol_ready_blocked: got %b expected 0", in_ready); else passed++;
        tick;
        total++; if (out_valid !== 4'b0001) $display("FAIL hol_valid: got %b expected 0001", out_valid); else passed++;
        total++; if (dat(0) !== 32'h11) $display("FAIL hol_stall_data: got %h expected 11", dat(0)); else passed++;
        out_ready = 4'b0001;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL hol_ready_released: got %b expected 1", in_ready); else passed++;
        tick;
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        total++; if (out_valid !== 4'b0001) $display("FAIL hol_refill_valid: got %b expected 0001", out_valid); else passed++;
        total++; if (dat(0) !== 32'h55) $display("FAIL hol_refill_data: got %h expected 55", dat(0)); else passed++;
        total++; if (cnt(0) !== 8'd1) $display("FAIL hol_count: got %0d expected 1", cnt(0)); else passed++;
    endtask

    task automatic test_counter_wrap;
        do_reset;
        out_ready = 4'b0100;
        for (int n = 1; n <= 257; n++) begin
            in_valid = 1'b1; in_select = 2'd2; in_data = n;
            tick;
            if (n == 256) begin
                total++; if (cnt(2) !== 8'd255) $display("FAIL wrap_pre_count: got %0d expected 255", cnt(2)); else passed++;
            end
        end
        in_valid = 1'b0;
        tick;
        total++; if (cnt(2) !== 8'd1) $display("FAIL wrap_count: got %0d expected 1", cnt(2)); else passed++;
        total++; if ({cnt(3), cnt(1), cnt(0)} !== 24'd0) $display("FAIL wrap_other_counts: got %h expected 0", {cnt(3), cnt(1), cnt(0)}); else passed++;
        out_ready = 4'b0000;
    endtask

    task automatic test_random;
        logic [W-1:0] q [4][$];
        logic [W-1:0] prev_data [4];
        logic [3:0]   prev_stall;
        int           mc [4];
        logic         hold;
        logic         exp_ready;
        logic [W-1:0] w;
        do_reset;
        prev_stall = 4'b0000;
        hold = 1'b0;
        for (int k = 0; k < 4; k++) mc[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_select = 2'($urandom_range(0, 3));
                in_data   = $urandom;
            end
            out_ready = 4'($urandom_range(0, 15));
            #1;
            for (int k = 0; k < 4; k++) begin
                total++; if (out_valid[k] !== (q[k].size() != 0)) $display("FAIL rnd_valid c=%0d ch%0d: got %b expected %b", c, k, out_valid[k], q[k].size() != 0); else passed++;
                if (prev_stall[k]) begin
                    total++; if (dat(k) !== prev_data[k]) $display("FAIL rnd_stable c=%0d ch%0d: got %h expected %h", c, k, dat(k), prev_data[k]); else passed++;
                end
            end
            exp_ready = (q[in_select].size() == 0) || out_ready[in_select];
            total++; if (in_ready !== exp_ready) $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, exp_ready); else passed++;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    w = q[k].pop_front();
                    mc[k]++;
                    total++; if (dat(k) !== w) $display("FAIL rnd_order c=%0d ch%0d: got %h expected %h", c, k, dat(k), w); else passed++;
                end
                prev_stall[k] = (q[k].size() != 0) && !out_ready[k];
                prev_data[k]  = dat(k);
            end
            if (in_valid && exp_ready) q[in_select].push_back(in_data);
            hold = in_valid && !exp_ready;
            tick;
        end
        in_valid = 1'b0; out_ready = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0) begin
                w = q[k].pop_front();
                mc[k]++;
                total++; if (dat(k) !== w) $display("FAIL rnd_final_data ch%0d: got %h expected %h", k, dat(k), w); else passed++;
            end
        end
        tick;
        total++; if (out_valid !== 4'b0000) $display("FAIL rnd_final_empty: got %b expected 0000", out_valid); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (cnt(k) !== 8'(mc[k])) $display("FAIL rnd_count ch%0d: got %0d expected %0d", k, cnt(k), 8'(mc[k])); else passed++;
        end
        out_ready = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_routing;
        test_streaming;
        test_head_of_line;
        test_counter_wrap;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux4_buffered.md
Name: demux4_buffered

Overview:
- 1-to-4 demultiplexer: the inverse of the core's general 4-input mux.
- Accepts one word per cycle on a valid/ready input port and routes it, by a 2-bit select, to one of four output channels.
- Each output channel has its own one-entry holding register and valid/ready handshake.
- Used to fan a single producer (e.g. write-back or bus response path) out to four consumers with independent back-pressure.

Parameters:
- OPERAND_WIDTH, 32, data width of input and every output channel.
- COUNT_WIDTH, 8, width of each per-channel delivered-word counter (wraps).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid && in_ready.
- in_select  input  2  target channel (0..3); sampled with in_data.
- in_data  input  OPERAND_WIDTH  input word.
- out_valid  output  4  bit k: channel k holding register full.
- out_ready  input  4  bit k: consumer k takes word this cycle.
- out_data  output  4*OPERAND_WIDTH  channel k occupies bits [k*OPERAND_WIDTH +: OPERAND_WIDTH].
- out_count  output  4*COUNT_WIDTH  channel k delivered-word count, [k*COUNT_WIDTH +: COUNT_WIDTH].

Behaviour:
- Reset (async, active-high, immediate): out_valid=4'b0000, all out_data=0, all out_count=0. rst asserted mid-transfer discards held words; no handshake completes while rst=1.
- in_ready is combinational: !out_valid[in_select] || out_ready[in_select].
  - Depends only on the selected channel.
  - Head-of-line blocking is intended: a word for a full channel stalls the input even if other channels are empty.
  - in_ready is meaningful only when in_valid=1. When in_valid=0 it still follows the formula.
- Input transfer (in_valid && in_ready at clock edge):
  - out_data[sel] <= in_data.
  - out_valid[sel] <= 1.
  - Latency: word visible on channel one cycle after acceptance; no combinational data path from input to output.
- Output transfer on channel k (out_valid[k] && out_ready[k]):
  - Register frees at the edge: out_valid[k] <= 0 unless refilled in the same cycle.
  - out_count[k] <= out_count[k]+1, wrapping 2^COUNT_WIDTH-1 -> 0.
- Simultaneous drain and fill of the same channel:
  - Both occur; out_valid[k] stays 1 and out_data[k] takes the new word.
  - Gives 1 word/cycle sustained throughput per channel.
- Channels other than sel are unaffected by an input transfer; their drains proceed independently in the same cycle.
- out_data[k] holds its value while out_valid[k]=0 (last word, or 0 after reset).
- Consumer must not depend on out_data when out_valid=0.
- Protocol rules for the producer:
  - in_select and in_data must stay stable while in_valid=1 && in_ready=0. Behaviour if violated: the word is routed per the select value at the accepting edge.
  - out_valid[k] never drops without out_ready[k].
  - out_data[k] is stable while out_valid[k]=1 && out_ready[k]=0.
- Any in_select value is legal (all 4 decoded); no error state.

Test Plan:
- Reset: assert rst mid-cycle with channel 2 full -> out_valid=0000 immediately, out_count all 0, out_data all 0; in_ready=1 for any select after release.
- Routing: send 0xA0,0xA1,0xA2,0xA3 with sel=0,1,2,3 on consecutive cycles, out_ready=0000 -> out_valid=1111 after 4th edge, channel k holds 0xA(k); then in_valid=1 with sel=1 gives in_ready=0.
- Streaming: sel=3, out_ready[3]=1, 10 back-to-back words 0x100..0x109 -> in_ready stays 1, channel 3 outputs each word one cycle after acceptance, out_count[3]=10.
- Head-of-line: channel 0 full, out_ready[0]=0, in sel=0 word 0x55 -> in_ready=0, channel 1 receives nothing; raise out_ready[0] -> 0x55 accepted that cycle, out_valid[0] remains 1 with data 0x55.
- Counter wrap: COUNT_WIDTH=8, deliver 257 words on channel 2 -> out_count[2]=1, other counters 0.
- Random: random in_valid/out_ready/in_select for 10k cycles vs scoreboard per channel -> no loss, no duplication, per-channel order preserved, out_data stable while stalled.
